// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding, default step counts and step-count helper
package multdiv_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam int MULT_STEPS_DEF = 16;
    localparam int DIV_STEPS_DEF = 32;
    function automatic int n_steps(input logic op_div, input int mult_steps, input int div_steps);
        return op_div ? div_steps : mult_steps;
    endfunction
endpackage

// File: rtl/multdiv_sequencer_step_counter.sv
// step_counter: clearable, enabled up-counter that parks at its terminal value
module step_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             at_terminal
);
    assign at_terminal = count == terminal;
    // reset and clear zero the count; enable advances it but never past terminal
    always_ff @(posedge clock) begin
        if (ctrl_reset || clear) count <= '0;
        else if (enable && !at_terminal) count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: control FSM sequencing load, iteration steps and result handshake
module multdiv_sequencer import multdiv_pkg::*; #(
    parameter int MULT_STEPS = MULT_STEPS_DEF,
    parameter int DIV_STEPS  = DIV_STEPS_DEF,
    parameter int CNT_W      = 5
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    output logic             load,
    output logic             op_div,
    output logic             step_en,
    output logic [CNT_W-1:0] step_idx,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception
);
    state_t state, state_nx;
    logic op_div_nx, exc, exc_nx, at_term;
    logic [CNT_W-1:0] count;
    logic req, conflict, dz;
    assign req      = ctrl_MULT | ctrl_DIV;
    assign conflict = ctrl_MULT & ctrl_DIV;
    assign dz       = ctrl_DIV & divisor_zero & ~ctrl_MULT;
    step_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .clear      (state == LOAD),
        .enable     (state == RUN),
        .terminal   (CNT_W'(n_steps(op_div, MULT_STEPS, DIV_STEPS) - 1)),
        .count      (count),
        .at_terminal(at_term)
    );
    // any request restarts from scratch; exception paths skip straight to DONE
    always_comb begin
        state_nx  = state == LOAD ? RUN : state == RUN ? (at_term ? DONE : RUN) : IDLE;
        op_div_nx = op_div;
        exc_nx    = 1'b0;
        if (req) begin
            state_nx  = (conflict || dz) ? DONE : LOAD;
            exc_nx    = conflict | dz;
            op_div_nx = conflict ? op_div : ctrl_DIV;
        end
    end
    // state, operation select and pending-exception flag
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state  <= IDLE;
            op_div <= 1'b0;
            exc    <= 1'b0;
        end else begin
            state  <= state_nx;
            op_div <= op_div_nx;
            exc    <= exc_nx;
        end
    end
    assign load           = state == LOAD;
    assign step_en        = state == RUN;
    assign busy           = load | step_en;
    assign step_idx       = step_en ? count : '0;
    assign data_resultRDY = state == DONE;
    assign data_exception = data_resultRDY & exc;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed self-checking bench for the multiply/divide sequencer
module tb_multdiv_sequencer;
    logic clk = 1'b0;
    logic ctrl_reset = 1'b1, ctrl_MULT = 1'b0, ctrl_DIV = 1'b0, divisor_zero = 1'b0;
    logic load, op_div, step_en, busy, data_resultRDY, data_exception;
    logic [4:0] step_idx;
    int n_cmp = 0, n_err = 0, rdy_cnt = 0, c0;

    always #5 clk = ~clk;

    multdiv_sequencer dut (
        .clock         (clk),
        .ctrl_reset    (ctrl_reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .divisor_zero  (divisor_zero),
        .load          (load),
        .op_div        (op_div),
        .step_en       (step_en),
        .step_idx      (step_idx),
        .busy          (busy),
        .data_resultRDY(data_resultRDY),
        .data_exception(data_exception)
    );

    // tally result pulses; each posedge sees the cycle that just ended
    always @(posedge clk) if (data_resultRDY) rdy_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic l, input logic o, input logic s,
                        input logic [4:0] i, input logic b, input logic r, input logic e);
        chk({tag, ".load"},  32'(load),           32'(l));
        chk({tag, ".op_div"}, 32'(op_div),        32'(o));
        chk({tag, ".step_en"}, 32'(step_en),      32'(s));
        chk({tag, ".step_idx"}, 32'(step_idx),    32'(i));
        chk({tag, ".busy"},  32'(busy),           32'(b));
        chk({tag, ".rdy"},   32'(data_resultRDY), 32'(r));
        chk({tag, ".exc"},   32'(data_exception), 32'(e));
    endtask

    task automatic req(input logic m, input logic d, input logic z);
        ctrl_MULT = m; ctrl_DIV = d; divisor_zero = z;
        @(negedge clk);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; divisor_zero = 1'b0;
    endtask

    task automatic full_op(input string tag, input logic div);
        int n;
        n = div ? 32 : 16;
        outs({tag, ".ld"}, 1, div, 0, 0, 1, 0, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            outs($sformatf("%s.st%0d", tag, i), 0, div, 1, 5'(i), 1, 0, 0);
        end
        @(negedge clk);
        outs({tag, ".done"}, 0, div, 0, 0, 0, 1, 0);
        @(negedge clk);
        outs({tag, ".idle"}, 0, div, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        outs("reset", 0, 0, 0, 0, 0, 0, 0);
        ctrl_reset = 1'b0;
        @(negedge clk);

        req(1, 0, 0);
        full_op("mul", 0);
        req(0, 1, 0);
        full_op("div", 1);

        req(0, 1, 1);
        outs("dz", 0, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        outs("dz.idle", 0, 1, 0, 0, 0, 0, 0);

        req(1, 1, 0);
        outs("cf1", 0, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        outs("cf1.idle", 0, 1, 0, 0, 0, 0, 0);
        req(1, 0, 0);
        full_op("mul2", 0);
        req(1, 1, 1);
        outs("cf0", 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        outs("cf0.idle", 0, 0, 0, 0, 0, 0, 0);

        c0 = rdy_cnt;
        req(1, 0, 0);
        outs("ab.ld", 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            outs($sformatf("ab.st%0d", i), 0, 0, 1, 5'(i), 1, 0, 0);
        end
        req(0, 1, 0);
        full_op("ab.div", 1);
        chk("ab.rdy_cnt", 32'(rdy_cnt - c0), 32'd1);

        req(1, 0, 0);
        outs("rs.ld", 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            outs($sformatf("rs.st%0d", i), 0, 0, 1, 5'(i), 1, 0, 0);
        end
        c0 = rdy_cnt;
        ctrl_reset = 1'b1;
        @(negedge clk);
        outs("rs1", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        outs("rs2", 0, 0, 0, 0, 0, 0, 0);
        ctrl_reset = 1'b0;
        repeat (20) @(negedge clk);
        outs("rs.quiet", 0, 0, 0, 0, 0, 0, 0);
        chk("rs.rdy_cnt", 32'(rdy_cnt - c0), 32'd0);
        req(1, 0, 0);
        full_op("post", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Control FSM for the iterative multiply/divide unit: accepts one-cycle ctrl_MULT/ctrl_DIV requests and sequences the datapath's operand load, iteration steps and result handshake.
- Owns the step counter formerly free-running off the clock; the counter becomes enable/clear controlled and terminal-count aware.
- Sits between the processor's multdiv issue logic and the multiply/divide datapath; it performs no arithmetic.

Parameters:
- MULT_STEPS, 16, iteration count for multiply (radix-4 Booth, 32-bit operands).
- DIV_STEPS, 32, iteration count for divide (restoring, 32-bit operands).
- CNT_W, 5, step counter width; must satisfy 2^CNT_W >= max(MULT_STEPS, DIV_STEPS).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- ctrl_MULT  in  1  one-cycle multiply request.
- ctrl_DIV  in  1  one-cycle divide request.
- divisor_zero  in  1  from datapath; meaningful only in the cycle ctrl_DIV is high.
- load  out  1  datapath captures operands; high exactly one cycle per accepted request.
- op_div  out  1  registered operation select (1 = divide); updated on accept, held until the next accept.
- step_en  out  1  datapath performs one iteration this cycle.
- step_idx  out  CNT_W  index of the current iteration, 0..N-1; valid while step_en = 1.
- busy  out  1  high in LOAD and RUN.
- data_resultRDY  out  1  result valid; one-cycle pulse.
- data_exception  out  1  high only alongside data_resultRDY, for divide-by-zero or a conflicting request.

Behaviour:
- Reset: the state goes to IDLE on the first edge with ctrl_reset = 1. All outputs (load, op_div, step_en, step_idx, busy, data_resultRDY, data_exception) are 0 from the following cycle. Reset overrides any simultaneous request.
- States: IDLE, LOAD, RUN, DONE. Outputs are decoded from registered state and counter only; no input-to-output combinational path.
- IDLE: step_idx = 0.
- IDLE to LOAD: on an edge with exactly one of ctrl_MULT or ctrl_DIV high, and not (ctrl_DIV and divisor_zero). op_div is registered at the same edge.
- LOAD: load = 1 and busy = 1 for one cycle; the counter is cleared to 0. Next state is RUN.
- RUN: step_en = 1 and busy = 1. step_idx increments each cycle from 0 to N-1, where N = DIV_STEPS if op_div else MULT_STEPS. The edge at step_idx = N-1 moves to DONE; the counter does not wrap.
- DONE: data_resultRDY = 1 for one cycle, busy = 0, step_en = 0. Next state is IDLE, unless a new request is accepted in this cycle.
- Latency, request sampled at edge E0:
  - load is high in the cycle after E0.
  - step_en is high for the N cycles after that.
  - data_resultRDY is high in cycle E0+N+2, i.e. 18 cycles for multiply and 34 for divide.
- Divide by zero: ctrl_DIV = 1 with divisor_zero = 1 goes directly to DONE, with data_exception = 1, op_div = 1, no load and no steps. data_resultRDY is high in the cycle after E0.
- Conflicting request: ctrl_MULT = ctrl_DIV = 1 goes directly to DONE, with data_exception = 1 and op_div unchanged.
- Request while busy (LOAD, RUN or DONE): the current operation is aborted without a data_resultRDY pulse. The new request is handled exactly as from IDLE, including the exception paths.
- Request held high for multiple cycles: each high cycle is a new request, so each one restarts the operation. Issue logic must pulse.

Decomposition:
- multdiv_pkg:
  - state enum {IDLE, LOAD, RUN, DONE};
  - constants MULT_STEPS_DEF = 16, DIV_STEPS_DEF = 32;
  - localparam function computing N from op_div.
- Sub-module step_counter: CNT_W-bit synchronous counter with inputs clock, ctrl_reset, clear, enable and terminal value, and outputs count and at_terminal. Clear takes priority over enable, and reset takes priority over both.
- The FSM stays in multdiv_sequencer.

Test Plan:
- Reset asserted for 2 cycles mid-RUN at step_idx = 7 → the cycle after the first reset edge has all outputs 0. No data_resultRDY follows, and the next ctrl_MULT behaves as from IDLE.
- ctrl_MULT pulse at E0 → load is high in cycle 1, step_en is high in cycles 2..17 with step_idx 0..15, and data_resultRDY = 1 with data_exception = 0 in cycle 18, then busy = 0.
- ctrl_DIV with divisor_zero = 0 → 32 steps with step_idx reaching 31 and no wrap to 0; data_resultRDY is high in cycle 34 with op_div = 1.
- ctrl_DIV with divisor_zero = 1 → data_resultRDY = data_exception = 1 in cycle 1; load and step_en are never high.
- ctrl_MULT and ctrl_DIV high together → exception pulse in cycle 1, with op_div retaining its prior value.
- ctrl_DIV during a multiply RUN at step_idx = 9 → load is high the next cycle and a 32-step divide follows; exactly one data_resultRDY occurs, for the divide only.
